// File: rtl/rv_pkg.sv
// Shared types for the SRAM arbiter: data width, FSM states, port ownership.
package rv_pkg;

    localparam int XLEN = 32;
    localparam int BEW  = XLEN / 8;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT,
        ARB_GAP
    } arb_state_t;

    typedef enum logic {
        OWN_INSTR,
        OWN_DATA
    } arb_owner_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
        return a & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/rv_rr_arbiter2.sv
// Two-way round-robin arbiter: combinational grant, registered last winner.
module rv_rr_arbiter2
    import rv_pkg::*;
(
    input  logic clk_i,
    input  logic arst_i,
    input  logic en_i,
    input  logic req_instr_i,
    input  logic req_data_i,
    output logic gnt_instr_o,
    output logic gnt_data_o
);

    arb_owner_t last_q, last_d;

    always_comb begin
        gnt_instr_o = 1'b0;
        gnt_data_o  = 1'b0;
        if (en_i) begin
            if (req_instr_i && req_data_i) begin
                gnt_instr_o = (last_q == OWN_DATA);
                gnt_data_o  = (last_q == OWN_INSTR);
            end else begin
                gnt_instr_o = req_instr_i;
                gnt_data_o  = req_data_i;
            end
        end
    end

    always_comb begin
        last_d = last_q;
        if (gnt_instr_o) begin
            last_d = OWN_INSTR;
        end else if (gnt_data_o) begin
            last_d = OWN_DATA;
        end
    end

    // Reset to data so the instruction port wins the first tie.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            last_q <= OWN_DATA;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/rv_sram_arbiter.sv
// Instruction/data arbiter in front of a single-outstanding SRAM driver.
// Optional WAIT watchdog enabled by defining RV_SRAM_ARB_TIMEOUT_EN.
module rv_sram_arbiter
    import rv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic            clk_i,
    input  logic            arst_i,
    input  logic            instr_req_i,
    input  logic [XLEN-1:0] instr_addr_i,
    output logic            instr_gnt_o,
    output logic            instr_rvalid_o,
    output logic [XLEN-1:0] instr_rdata_o,
    output logic            instr_err_o,
    input  logic            data_req_i,
    input  logic            data_we_i,
    input  logic [BEW-1:0]  data_be_i,
    input  logic [XLEN-1:0] data_addr_i,
    input  logic [XLEN-1:0] data_wdata_i,
    output logic            data_gnt_o,
    output logic            data_rvalid_o,
    output logic [XLEN-1:0] data_rdata_o,
    output logic            data_err_o,
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [BEW-1:0]  mem_be_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [XLEN-1:0] mem_wdata_o,
    input  logic            mem_rvalid_i,
    input  logic [XLEN-1:0] mem_rdata_i
);

    arb_state_t      state_q, state_d;
    arb_owner_t      owner_q;
    logic            we_q;
    logic [BEW-1:0]  be_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [XLEN-1:0] irdata_q;
    logic [XLEN-1:0] drdata_q;
    logic            gnt_en;
    logic            gnt_instr;
    logic            gnt_data;
    logic            timeout;
    logic            complete;

    assign gnt_en = (state_q == ARB_IDLE) && !arst_i;

    rv_rr_arbiter2 u_rr (
        .clk_i       (clk_i),
        .arst_i      (arst_i),
        .en_i        (gnt_en),
        .req_instr_i (instr_req_i),
        .req_data_i  (data_req_i),
        .gnt_instr_o (gnt_instr),
        .gnt_data_o  (gnt_data)
    );

`ifdef RV_SRAM_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CW-1:0] cnt_q;
    logic          err_q;

    assign timeout = !mem_rvalid_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (state_q == ARB_ISSUE) begin
                cnt_q <= '0;
            end else if (state_q == ARB_WAIT && !mem_rvalid_i) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (complete) begin
                err_q <= timeout;
            end
        end
    end
`else
    logic unused_timeout;

    assign timeout        = 1'b0;
    assign unused_timeout = (TIMEOUT_CYCLES > 0);
`endif

    assign complete = (state_q == ARB_WAIT) && (mem_rvalid_i || timeout);

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARB_IDLE:  if (gnt_instr || gnt_data) state_d = ARB_ISSUE;
            ARB_ISSUE: state_d = ARB_WAIT;
            ARB_WAIT:  if (complete) state_d = ARB_GAP;
            ARB_GAP:   state_d = ARB_IDLE;
            default:   state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        instr_gnt_o    = gnt_instr;
        data_gnt_o     = gnt_data;
        mem_req_o      = (state_q == ARB_ISSUE);
        instr_rvalid_o = (state_q == ARB_GAP) && (owner_q == OWN_INSTR);
        data_rvalid_o  = (state_q == ARB_GAP) && (owner_q == OWN_DATA);
`ifdef RV_SRAM_ARB_TIMEOUT_EN
        instr_err_o    = instr_rvalid_o && err_q;
        data_err_o     = data_rvalid_o && err_q;
`else
        instr_err_o    = 1'b0;
        data_err_o     = 1'b0;
`endif
    end

    // Fields stay registered until the next grant so the driver sees them stable.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            owner_q  <= OWN_DATA;
            we_q     <= 1'b0;
            be_q     <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            irdata_q <= '0;
            drdata_q <= '0;
        end else begin
            if (gnt_instr) begin
                owner_q <= OWN_INSTR;
                we_q    <= 1'b0;
                be_q    <= '1;
                addr_q  <= word_align(instr_addr_i);
                wdata_q <= '0;
            end else if (gnt_data) begin
                owner_q <= OWN_DATA;
                we_q    <= data_we_i;
                be_q    <= data_be_i;
                addr_q  <= word_align(data_addr_i);
                wdata_q <= data_wdata_i;
            end
            if (complete && owner_q == OWN_INSTR) begin
                irdata_q <= timeout ? '0 : mem_rdata_i;
            end
            if (complete && owner_q == OWN_DATA) begin
                drdata_q <= timeout ? '0 : mem_rdata_i;
            end
        end
    end

    assign mem_we_o      = we_q;
    assign mem_be_o      = be_q;
    assign mem_addr_o    = addr_q;
    assign mem_wdata_o   = wdata_q;
    assign instr_rdata_o = irdata_q;
    assign data_rdata_o  = drdata_q;

endmodule
